// File: rtl/wb_bus_rr_if.sv
// Wishbone B3 shared-bus bundle for wb_bus_rr: flat master-side and slave-side vectors.
// Modport slave is the interconnect's view; modport master is the surrounding system's view.
interface wb_bus_rr_if #(
  parameter int MASTERS = 2,
  parameter int SLAVES  = 10
);
  logic [32*MASTERS-1:0] m_adr_i, m_dat_i, m_dat_o;
  logic [4*MASTERS-1:0]  m_sel_i;
  logic [MASTERS-1:0]    m_we_i, m_cyc_i, m_stb_i;
  logic [3*MASTERS-1:0]  m_cti_i;
  logic [2*MASTERS-1:0]  m_bte_i;
  logic [MASTERS-1:0]    m_ack_o, m_err_o, m_rty_o;

  logic [32*SLAVES-1:0]  s_adr_o, s_dat_o, s_dat_i;
  logic [4*SLAVES-1:0]   s_sel_o;
  logic [SLAVES-1:0]     s_we_o, s_cyc_o, s_stb_o;
  logic [3*SLAVES-1:0]   s_cti_o;
  logic [2*SLAVES-1:0]   s_bte_o;
  logic [SLAVES-1:0]     s_ack_i, s_err_i, s_rty_i;

  logic bus_hold_i, bus_hold_ack_o;

  modport slave (
    input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
    input  bus_hold_i,
    output bus_hold_ack_o
  );

  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i,
    output bus_hold_i,
    input  bus_hold_ack_o
  );
endinterface

// File: rtl/wb_bus_rr.sv
// Wishbone B3 shared bus: round-robin arbiter, mask/base decode, error slave, watchdog, bus hold.
// Optional write snoop port enabled by defining WB_BUS_SNOOP_EN.
module wb_bus_rr_dec (
  input  logic [31:0] adr,
  input  logic [31:0] base,
  input  logic [31:0] mask,
  output logic        hit
);
  assign hit = ((adr & mask) == base);
endmodule

module wb_bus_rr #(
  parameter int MASTERS = 2,
  parameter int SLAVES  = 10,
  parameter logic [32*SLAVES-1:0] SLAVE_BASE = (32*SLAVES)'({
    32'hF000_0000, 32'hE000_0000, 32'hD000_0000, 32'hC000_0000,
    32'hB000_0000, 32'hA000_0000, 32'h9000_0000, 32'h8000_0000,
    32'h7000_0000, 32'h6000_0000, 32'h5000_0000, 32'h4000_0000,
    32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
  parameter logic [32*SLAVES-1:0] SLAVE_MASK = {SLAVES{32'hF000_0000}},
  parameter int TIMEOUT = 256
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  wb_bus_rr_if.slave   bus
`ifdef WB_BUS_SNOOP_EN
  ,
  output logic [31:0]  snoop_adr_o,
  output logic         snoop_en_o
`endif
);
  localparam int MW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int SW = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t          state, state_d;
  logic [MW-1:0]   gnt, gnt_d, last, last_d;
  logic            hold_ack, hold_ack_d;

  logic            gcyc, gstb, gwe;
  logic [31:0]     gadr, gdat;
  logic [3:0]      gsel;
  logic [2:0]      gcti;
  logic [1:0]      gbte;

  logic [SLAVES-1:0] hit_raw, hit;
  logic            any;
  logic [SW-1:0]   sidx;
  logic            sack, serr, srty, unmapped, err_out, term, wd_exp;
  logic            err_q;
  logic [WW-1:0]   wd_cnt;
  logic [31:0]     rdat;

  // State register: arbitration plus error-slave and watchdog state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      gnt      <= '0;
      last     <= MW'(MASTERS-1);
      hold_ack <= 1'b0;
      err_q    <= 1'b0;
      wd_cnt   <= '0;
    end else begin
      state    <= state_d;
      gnt      <= gnt_d;
      last     <= last_d;
      hold_ack <= hold_ack_d;
      err_q    <= unmapped & ~err_q;
      wd_cnt   <= (TIMEOUT == 0 || !gstb || term || wd_exp) ? '0 : wd_cnt + 1'b1;
    end
  end

  // Next-state: hold parks the bus only from IDLE, so an owner is never pre-empted
  always_comb begin
    state_d    = state;
    gnt_d      = gnt;
    last_d     = last;
    hold_ack_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.bus_hold_i) begin
          hold_ack_d = 1'b1;
        end else if (|bus.m_cyc_i) begin
          logic found;
          int   j;
          found = 1'b0;
          j     = 0;
          for (int i = 1; i <= MASTERS; i++) begin
            j = (int'(last) + i) % MASTERS;
            if (!found && bus.m_cyc_i[j]) begin
              found = 1'b1;
              gnt_d = MW'(j);
            end
          end
          state_d = GRANTED;
          last_d  = gnt_d;
        end
      end
      GRANTED: begin
        if (!bus.m_cyc_i[gnt]) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Granted master's request, forced to zero when nobody owns the bus
  always_comb begin
    gcyc = (state == GRANTED) & bus.m_cyc_i[gnt];
    gstb = gcyc & bus.m_stb_i[gnt];
    gwe  = 1'b0;
    gadr = '0;
    gdat = '0;
    gsel = '0;
    gcti = '0;
    gbte = '0;
    if (gcyc) begin
      gwe  = bus.m_we_i[gnt];
      gadr = bus.m_adr_i[32*gnt +: 32];
      gdat = bus.m_dat_i[32*gnt +: 32];
      gsel = bus.m_sel_i[4*gnt +: 4];
      gcti = bus.m_cti_i[3*gnt +: 3];
      gbte = bus.m_bte_i[2*gnt +: 2];
    end
  end

  for (genvar s = 0; s < SLAVES; s++) begin : g_dec
    wb_bus_rr_dec u_dec (
      .adr  (gadr),
      .base (SLAVE_BASE[32*s +: 32]),
      .mask (SLAVE_MASK[32*s +: 32]),
      .hit  (hit_raw[s])
    );
  end

  // Output logic: lowest-index hit wins; ack blocks a same-cycle watchdog error
  always_comb begin
    hit  = '0;
    any  = 1'b0;
    sidx = '0;
    for (int s = 0; s < SLAVES; s++) begin
      if (hit_raw[s] && !any) begin
        hit[s] = 1'b1;
        any    = 1'b1;
        sidx   = SW'(s);
      end
    end
    sack     = gcyc & any & bus.s_ack_i[sidx];
    serr     = gcyc & any & bus.s_err_i[sidx];
    srty     = gcyc & any & bus.s_rty_i[sidx];
    unmapped = gstb & ~any;
    err_out  = err_q & unmapped;
    term     = sack | serr | srty | err_out;
    wd_exp   = (TIMEOUT != 0) && gstb && !term && (wd_cnt == WW'(TIMEOUT-1));
    rdat     = (gcyc & any) ? bus.s_dat_i[32*sidx +: 32] : 32'h0;

    bus.m_dat_o = '0;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    bus.m_rty_o = '0;
    for (int m = 0; m < MASTERS; m++) bus.m_dat_o[32*m +: 32] = rdat;
    bus.m_ack_o[gnt] = sack;
    bus.m_err_o[gnt] = serr | err_out | wd_exp;
    bus.m_rty_o[gnt] = srty;

    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.s_sel_o = '0;
    bus.s_cti_o = '0;
    bus.s_bte_o = '0;
    for (int s = 0; s < SLAVES; s++) begin
      bus.s_adr_o[32*s +: 32] = gadr;
      bus.s_dat_o[32*s +: 32] = gdat;
      bus.s_sel_o[4*s +: 4]   = gsel;
      bus.s_cti_o[3*s +: 3]   = gcti;
      bus.s_bte_o[2*s +: 2]   = gbte;
    end
    bus.s_we_o  = {SLAVES{gwe}};
    bus.s_cyc_o = {SLAVES{gcyc}} & hit;
    bus.s_stb_o = {SLAVES{gstb}} & hit;
    bus.bus_hold_ack_o = hold_ack;
  end

`ifdef WB_BUS_SNOOP_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      snoop_en_o  <= 1'b0;
      snoop_adr_o <= '0;
    end else begin
      snoop_en_o <= gwe & sack;
      if (gwe & sack) snoop_adr_o <= gadr;
    end
  end
`endif
endmodule

// File: tb/tb_wb_bus_rr.sv
// Directed bench for wb_bus_rr: 2 masters, 10 slaves, watchdog TIMEOUT=8.
module tb_wb_bus_rr;
  logic clk = 1'b0;
  logic rst_ni;
  logic [9:0] ack_mask;
  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  wb_bus_rr_if #(.MASTERS(2), .SLAVES(10)) bus ();

`ifdef WB_BUS_SNOOP_EN
  logic [31:0] snoop_adr;
  logic        snoop_en;
`endif

  wb_bus_rr #(.MASTERS(2), .SLAVES(10), .TIMEOUT(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
`ifdef WB_BUS_SNOOP_EN
    ,
    .snoop_adr_o (snoop_adr),
    .snoop_en_o  (snoop_en)
`endif
  );

  // Zero-wait slaves: ack whenever strobed unless masked; slave 2 returns DEADBEEF
  always_comb begin
    bus.s_ack_i = bus.s_stb_o & ack_mask;
    bus.s_err_i = '0;
    bus.s_rty_i = '0;
    bus.s_dat_i = '0;
    for (int s = 0; s < 10; s++)
      bus.s_dat_i[32*s +: 32] = (s == 2) ? 32'hDEAD_BEEF : (32'hC0DE_0000 + 32'(s));
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic mreq(input int m, input logic [31:0] a);
    bus.m_adr_i[32*m +: 32] = a;
    bus.m_dat_i[32*m +: 32] = a ^ 32'h5A5A_5A5A;
    bus.m_sel_i[4*m +: 4]   = 4'hF;
    bus.m_we_i[m]  = 1'b0;
    bus.m_cyc_i[m] = 1'b1;
    bus.m_stb_i[m] = 1'b1;
  endtask

  task automatic mdrop(input int m);
    bus.m_cyc_i[m] = 1'b0;
    bus.m_stb_i[m] = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0;
    ack_mask = 10'b11_1101_1111;
    bus.m_adr_i = '0; bus.m_dat_i = '0; bus.m_sel_i = '0;
    bus.m_we_i = '0;  bus.m_cyc_i = '0; bus.m_stb_i = '0;
    bus.m_cti_i = '0; bus.m_bte_i = '0; bus.bus_hold_i = 1'b0;

    // Reset state
    step(); step();
    smp();
    chk("rst_scyc", bus.s_cyc_o, 0);
    chk("rst_ack", bus.m_ack_o, 0);
    chk("rst_hold_ack", bus.bus_hold_ack_o, 0);
    chk("rst_mdat", bus.m_dat_o, 0);
    step();
    rst_ni = 1'b1;

    // Single read from slave 2
    mreq(0, 32'h2000_0010);
    smp();
    chk("t1_not_yet", bus.s_cyc_o, 0);
    step(); smp();
    chk("t1_scyc", bus.s_cyc_o, 10'b00_0000_0100);
    chk("t1_ack", bus.m_ack_o, 2'b01);
    chk("t1_dat_m0", bus.m_dat_o[31:0], 32'hDEAD_BEEF);
    chk("t1_dat_m1", bus.m_dat_o[63:32], 32'hDEAD_BEEF);
    chk("t1_sadr", bus.s_adr_o[95:64], 32'h2000_0010);
    step(); mdrop(0); smp();
    chk("t1_ack_end", bus.m_ack_o, 0);
    chk("t1_scyc_end", bus.s_cyc_o, 0);
    step();

    // Reset pulse so master 0 has first priority again
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;

    // Two masters contending: 4 transfers each, alternating owners
    mreq(0, 32'h1000_0000);
    mreq(1, 32'h1000_0004);
    smp();
    chk("t2_idle", bus.m_ack_o, 0);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        step(); smp();
        chk($sformatf("t2_r%0d_ack", r), bus.m_ack_o, 64'(1 << (r % 2)));
        chk($sformatf("t2_r%0d_scyc", r), bus.s_cyc_o, 10'b00_0000_0010);
      end
      chk($sformatf("t2_r%0d_dat", r), bus.m_dat_o[31:0], 32'hC0DE_0001);
      step(); mdrop(r % 2); smp();
      chk($sformatf("t2_r%0d_dead1", r), bus.m_ack_o, 0);
      step(); mreq(r % 2, 32'h1000_0000 + 32'(4 * (r % 2))); smp();
      chk($sformatf("t2_r%0d_dead2", r), bus.m_ack_o, 0);
    end
    mdrop(0); mdrop(1);
    step();

    // Unmapped address from master 1
    mreq(1, 32'hF000_0000);
    smp();
    step(); smp();
    chk("t3_scyc", bus.s_cyc_o, 0);
    chk("t3_sstb", bus.s_stb_o, 0);
    chk("t3_no_err_yet", bus.m_err_o, 0);
    step(); smp();
    chk("t3_err", bus.m_err_o, 2'b10);
    step(); mdrop(1); smp();
    chk("t3_err_end", bus.m_err_o, 0);
    step();

    // Watchdog on silent slave 5
    mreq(0, 32'h5000_0000);
    smp();
    for (int k = 1; k <= 7; k++) begin
      step(); smp();
      chk($sformatf("t4_quiet_c%0d", k), bus.m_err_o, 0);
    end
    step(); smp();
    chk("t4_wd_err", bus.m_err_o, 2'b01);
    chk("t4_stb_kept", bus.s_stb_o, 10'b00_0010_0000);
    for (int k = 9; k <= 15; k++) begin
      step(); smp();
      chk($sformatf("t4_restart_c%0d", k), bus.m_err_o, 0);
    end
    step(); ack_mask[5] = 1'b1; smp();
    chk("t4_late_ack", bus.m_ack_o, 2'b01);
    chk("t4_ack_wins", bus.m_err_o, 0);
    step(); mdrop(0); ack_mask[5] = 1'b0;
    step();

    // Bus hold raised while master 0 owns the bus
    mreq(0, 32'h3000_0000);
    smp();
    step(); bus.bus_hold_i = 1'b1; mreq(1, 32'h3000_0004); smp();
    chk("t5_owner_ack", bus.m_ack_o, 2'b01);
    chk("t5_no_hold_granted", bus.bus_hold_ack_o, 0);
    step(); mdrop(0); smp();
    chk("t5_drop_ack", bus.m_ack_o, 0);
    step(); smp();
    chk("t5_idle_ack", bus.m_ack_o, 0);
    chk("t5_hold_not_yet", bus.bus_hold_ack_o, 0);
    step(); smp();
    chk("t5_hold_ack", bus.bus_hold_ack_o, 1);
    chk("t5_parked_ack", bus.m_ack_o, 0);
    chk("t5_parked_scyc", bus.s_cyc_o, 0);
    step(); smp();
    chk("t5_hold_ack2", bus.bus_hold_ack_o, 1);
    chk("t5_parked_ack2", bus.m_ack_o, 0);
    step(); bus.bus_hold_i = 1'b0; smp();
    chk("t5_release_ack", bus.m_ack_o, 0);
    step(); smp();
    chk("t5_m1_granted", bus.m_ack_o, 2'b10);
    chk("t5_hold_ack_off", bus.bus_hold_ack_o, 0);
    step(); mdrop(1);
    step();

    // Asynchronous reset mid-burst
    mreq(0, 32'h1000_0008);
    smp();
    step(); smp();
    chk("t6_pre_ack", bus.m_ack_o, 2'b01);
    mreq(1, 32'h1000_000C);
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_scyc", bus.s_cyc_o, 0);
    chk("t6_rst_sstb", bus.s_stb_o, 0);
    chk("t6_rst_ack", bus.m_ack_o, 0);
    step(); step();
    rst_ni = 1'b1;
    smp();
    chk("t6_idle_after", bus.m_ack_o, 0);
    step(); smp();
    chk("t6_first_m0", bus.m_ack_o, 2'b01);
    mdrop(0); mdrop(1);
    step(); step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
